otter_muldiv_seq: RTL and testbench
===================================

// Module: otter_muldiv_seq
// PURPOSE
//  Multi-cycle RV32M multiply/divide sequencer beside the EX-stage ALU of the pipelined OTTER.
//  Accepts one M-extension op at a time from EX and runs a radix-2 shift-add multiply or a restoring divide.
//  Stalls the pipeline while busy and returns the XLEN-bit result with a one-cycle done pulse.
// PARAMETERS
//  XLEN       32  operand/result width; iteration count = XLEN
//  EARLY_OUT  1   1: divide-by-zero and signed overflow skip CALC/FIX; 0: run full sequence
// PORTS
//  CLK     in   1     clock; all state updates on rising edge
//  RST     in   1     synchronous, active-high reset
//  start   in   1     EX holds a valid M-op this cycle
//  func3   in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  A       in   XLEN  rs1 operand (dividend / multiplicand)
//  B       in   XLEN  rs2 operand (divisor / multiplier)
//  flush   in   1     squash in-flight op (branch taken/trap)
//  stall   out  1     hold IF/ID/EX; combinational
//  done    out  1     registered; result valid this cycle only
//  Result  out  XLEN  registered; held until next done
// BEHAVIOUR
//  States: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
//  Reset: state=IDLE, done=0, Result=0, counter=0, internal regs=0. RST wins over flush/start.
//  IDLE: start=1 captures A, B, func3 at the edge -> PREP. start ignored in every other state.
//  stall = (state==IDLE & start & ~flush) | state in {PREP,CALC,FIX}. stall=0 in DONE, so EX advances.
//  PREP (1 cycle): take |A|,|B| per signedness (MUL/MULHU/DIVU/REMU unsigned; MULH both signed;
//   MULHSU A signed, B unsigned; DIV/REM both signed). Record negate flag:
//   mul = sA^sB; quotient = sA^sB; remainder = sA.
//   EARLY_OUT=1 and divide op with B==0, or DIV/REM with A=0x8000_0000,B=0xFFFF_FFFF:
//   load special Result -> DONE. Otherwise counter=0 -> CALC.
//  Special results: DIV/DIVU by 0 -> all ones; REM/REMU by 0 -> A; DIV overflow -> 0x8000_0000; REM overflow -> 0.
//   EARLY_OUT=0 must yield the same values via the normal path plus FIX.
//  CALC (exactly XLEN cycles, counter 0..XLEN-1):
//   mul: 2*XLEN-bit product; if multiplier LSB then add multiplicand to upper half; shift right 1.
//   div: remainder shifts in the dividend MSB; if rem>=divisor, subtract and set quotient bit.
//   counter==XLEN-1 -> FIX.
//  FIX (1 cycle): apply negate flag (two's complement, full 2*XLEN for mul).
//   Select Result: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder. -> DONE.
//  DONE (1 cycle): done=1 -> IDLE.
//  Latency, start accepted in cycle 0: normal done in cycle XLEN+3 (35); early-out done in cycle 2.
//  Back-to-back: next start earliest in the cycle after DONE.
//  flush: any non-IDLE state -> IDLE at the edge. No done for the squashed op; Result unchanged.
//   stall drops next cycle. flush with start in IDLE: op not captured. flush in DONE: done still pulses.
//  Counter width clog2(XLEN)+1; no wrap beyond XLEN-1.
//  All arithmetic is unsigned on magnitudes; sign handled only in PREP/FIX.
// TESTING
//  MUL A=7,B=0xFFFF_FFFD -> Result=0xFFFF_FFEB, done in cycle 35, stall high cycles 0-34.
//  MULH A=B=0x8000_0000 -> 0x4000_0000; MULHU same -> 0x4000_0000; MULHSU A=0xFFFF_FFFF,B=2 -> 0xFFFF_FFFF.
//  DIV A=0xFFFF_FFF9(-7),B=2 -> 0xFFFF_FFFD; REM same -> 0xFFFF_FFFF; DIVU 100/7 -> 14, REMU -> 2.
//  EARLY_OUT=1: DIV x/0 -> 0xFFFF_FFFF in cycle 2; REMU 0x1234/0 -> 0x1234; DIV 0x8000_0000/-1 -> 0x8000_0000.
//  Start DIVU, flush at cycle 10 -> IDLE at cycle 11, no done, stall=0 in cycle 11.
//   New MUL 3*5 started in cycle 11 -> 15 in cycle 46.
//  RST asserted mid-CALC -> next cycle done=0, Result=0, stall=0; start held during RST is ignored.

Source files
------------

// File: rtl/otter_muldiv_seq.sv
// Purpose : multi-cycle RV32M multiply/divide sequencer beside the EX-stage ALU (radix-2 shift-add / restoring divide).
// Latency : start accepted in cycle 0 -> done in cycle XLEN+3; divide-by-zero / signed overflow early-out -> done in cycle 2.
// Backpres: one op at a time; stall holds IF/ID/EX from acceptance until DONE; start ignored outside IDLE.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   start, func3    M-op valid from EX and its funct3 (000 MUL .. 111 REMU)
//   A, B            rs1 / rs2 operands
//   flush           squash the in-flight op (no done, Result unchanged)
//   stall           combinational pipeline hold
//   done, Result    registered one-cycle completion pulse and held result
module otter_muldiv_seq #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state, state_n;
  logic [2:0]        op;
  logic [XLEN-1:0]   a_r, b_r;
  logic [XLEN-1:0]   opnd;      // |A| multiplicand or |B| divisor
  logic [2*XLEN-1:0] acc;       // mul: {upper, multiplier}; div: {remainder, dividend/quotient}
  logic              neg;
  logic [CW-1:0]     cnt;

  // Operand decode (valid from PREP onward, op captured in IDLE)
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf, early, last;
  logic [XLEN-1:0] a_mag, b_mag, special;

  assign is_div  = op[2];
  assign a_sgn   = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
  assign b_sgn   = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
  assign a_neg   = a_sgn & a_r[XLEN-1];
  assign b_neg   = b_sgn & b_r[XLEN-1];
  assign a_mag   = a_neg ? (~a_r + 1'b1) : a_r;
  assign b_mag   = b_neg ? (~b_r + 1'b1) : b_r;
  assign b_zero  = (b_r == '0);
  assign ovf     = is_div & ~op[0] & (a_r == {1'b1, {(XLEN-1){1'b0}}}) & (&b_r);
  assign early   = EARLY_OUT & is_div & (b_zero | ovf);
  // REM: by zero -> A, overflow -> 0; DIV: by zero -> all ones, overflow -> most negative
  assign special = op[1] ? (b_zero ? a_r : '0) : (b_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}});
  assign last    = (cnt == CW'(XLEN-1));

  // One iteration of shift-add multiply: carry out of the upper add shifts into the top bit
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
  assign mul_nxt = {mul_sum, acc[XLEN-1:1]};

  // One iteration of restoring divide on {remainder, dividend} shifted left by one
  logic [XLEN:0]     div_hi;
  logic [XLEN-1:0]   div_dif;
  logic              div_ge;
  logic [2*XLEN-1:0] div_nxt;
  assign div_hi  = acc[2*XLEN-1:XLEN-1];
  assign div_ge  = (div_hi >= {1'b0, opnd});
  assign div_dif = div_hi[XLEN-1:0] - opnd;
  assign div_nxt = {(div_ge ? div_dif : div_hi[XLEN-1:0]), acc[XLEN-2:0], div_ge};

  // Sign fix-up and result select
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]   q_fin, r_fin, fix_res;
  assign prod_fin = neg ? (~acc + 1'b1) : acc;
  assign q_fin    = neg ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
  assign r_fin    = neg ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
  assign fix_res  = is_div ? (op[1] ? r_fin : q_fin)
                           : ((op[1:0] == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN]);

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    case (state)
      S_IDLE: begin
        stall = start & ~flush;
        if (start & ~flush) state_n = S_PREP;
      end
      S_PREP: begin
        stall   = 1'b1;
        state_n = early ? S_DONE : S_CALC;
      end
      S_CALC: begin
        stall = 1'b1;
        if (last) state_n = S_FIX;
      end
      S_FIX: begin
        stall   = 1'b1;
        state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush && state != S_IDLE) state_n = S_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op     <= '0;
      a_r    <= '0;
      b_r    <= '0;
      opnd   <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      Result <= '0;
    end else begin
      done <= (state_n == S_DONE);
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            op  <= func3;
            a_r <= A;
            b_r <= B;
          end
        end
        S_PREP: begin
          acc  <= is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
          opnd <= is_div ? b_mag : a_mag;
          // Quotient by zero stays all ones regardless of dividend sign
          neg  <= is_div ? (op[1] ? a_neg : ((a_neg ^ b_neg) & ~b_zero)) : (a_neg ^ b_neg);
          cnt  <= '0;
          if (early && !flush) Result <= special;
        end
        S_CALC: begin
          acc <= is_div ? div_nxt : mul_nxt;
          if (!last) cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          if (!flush) Result <= fix_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_muldiv_seq.sv
// Purpose : directed self-checking bench for otter_muldiv_seq (early-out and full-sequence instances side by side).
// Latency : checks done cycle per op (35 normal, 2 early-out on the early-out instance).
// Backpres: checks stall window, flush squash/DONE behaviour and mid-op reset.
module tb_otter_muldiv_seq;

  logic        CLK = 1'b0;
  logic        RST, start, flush;
  logic [2:0]  func3;
  logic [31:0] A, B;
  logic        stall, done, stall0, done0;
  logic [31:0] Result, result0;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res;

  always #5 CLK = ~CLK;

  otter_muldiv_seq #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
    .CLK(CLK), .RST(RST), .start(start), .func3(func3), .A(A), .B(B),
    .flush(flush), .stall(stall), .done(done), .Result(Result)
  );

  otter_muldiv_seq #(.XLEN(32), .EARLY_OUT(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .start(start), .func3(func3), .A(A), .B(B),
    .flush(flush), .stall(stall0), .done(done0), .Result(result0)
  );

  typedef struct {
    string       name;
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] r, input int l);
    mk.name = n; mk.fn = f; mk.a = a; mk.b = b; mk.res = r; mk.lat = l;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int dcyc, dcnt, d0cyc, scnt;
    logic [31:0] r, r0;
    dcyc = -1; dcnt = 0; d0cyc = -1; scnt = 0; r = '0; r0 = '0;
    @(posedge CLK); #1;
    start = 1'b1; func3 = v.fn; A = v.a; B = v.b;
    @(negedge CLK);
    if (stall) scnt++;
    @(posedge CLK); #1;
    start = 1'b0; func3 = ~v.fn; A = ~v.a; B = ~v.b;
    for (int c = 1; c <= 45; c++) begin
      @(negedge CLK);
      if (stall) scnt++;
      if (done) begin
        dcnt++;
        if (dcyc < 0) begin dcyc = c; r = Result; end
      end
      if (done0 && d0cyc < 0) begin d0cyc = c; r0 = result0; end
    end
    check({v.name, " done_cycle"}, dcyc, v.lat);
    check({v.name, " done_count"}, dcnt, 1);
    check({v.name, " result"}, r, v.res);
    check({v.name, " result_held"}, Result, v.res);
    check({v.name, " stall_cycles"}, scnt, v.lat);
    check({v.name, " full_done_cycle"}, d0cyc, 35);
    check({v.name, " full_result"}, r0, v.res);
    last_res = v.res;
  endtask

  initial begin
    int dcyc, dcnt, d0cyc;
    vecs.push_back(mk("MUL_7xm3",       3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 35));
    vecs.push_back(mk("MULH_min",       3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35));
    vecs.push_back(mk("MULHU_min",      3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35));
    vecs.push_back(mk("MULHSU_m1x2",    3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 35));
    vecs.push_back(mk("MULH_m1xm1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 35));
    vecs.push_back(mk("MULHU_max",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35));
    vecs.push_back(mk("DIV_m7d2",       3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 35));
    vecs.push_back(mk("REM_m7d2",       3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 35));
    vecs.push_back(mk("DIV_7dm2",       3'b100, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 35));
    vecs.push_back(mk("REM_7dm2",       3'b110, 32'd7,        32'hFFFF_FFFE, 32'd1,        35));
    vecs.push_back(mk("DIVU_100d7",     3'b101, 32'd100,      32'd7,        32'd14,       35));
    vecs.push_back(mk("REMU_100d7",     3'b111, 32'd100,      32'd7,        32'd2,        35));
    vecs.push_back(mk("DIVU_maxd1",     3'b101, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 35));
    vecs.push_back(mk("DIV_5d0",        3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, 2));
    vecs.push_back(mk("DIV_m7d0",       3'b100, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFFF, 2));
    vecs.push_back(mk("DIVU_7d0",       3'b101, 32'd7,        32'd0,        32'hFFFF_FFFF, 2));
    vecs.push_back(mk("REMU_1234d0",    3'b111, 32'h0000_1234, 32'd0,        32'h0000_1234, 2));
    vecs.push_back(mk("REM_m7d0",       3'b110, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 2));
    vecs.push_back(mk("DIV_ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2));
    vecs.push_back(mk("REM_ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2));

    // Reset state
    RST = 1'b1; start = 1'b0; flush = 1'b0; func3 = '0; A = '0; B = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("reset done", done, 0);
    check("reset Result", Result, 0);
    check("reset stall", stall, 0);
    check("reset full Result", result0, 0);

    foreach (vecs[i]) run_op(vecs[i]);

    // Flush mid-divide at cycle 10, then a new MUL in cycle 11
    @(posedge CLK); #1;
    start = 1'b1; func3 = 3'b101; A = 32'd100; B = 32'd7;          // cycle 0
    @(posedge CLK); #1; start = 1'b0;                                // cycle 1
    repeat (9) @(posedge CLK);
    #1 flush = 1'b1;                                                 // cycle 10
    @(negedge CLK);
    check("flush stall_at_10", stall, 1);
    @(posedge CLK); #1 flush = 1'b0;                                 // cycle 11
    #1;
    check("flush stall_at_11", stall, 0);
    check("flush done_at_11", done, 0);
    check("flush Result_unchanged", Result, last_res);
    check("flush full_Result_unchanged", result0, last_res);
    start = 1'b1; func3 = 3'b000; A = 32'd3; B = 32'd5;
    @(posedge CLK); #1; start = 1'b0; A = '0; B = '0;                // cycle 12
    dcyc = -1; dcnt = 0; d0cyc = -1;
    for (int c = 12; c <= 55; c++) begin
      @(negedge CLK);
      if (done) begin dcnt++; if (dcyc < 0) dcyc = c; end
      if (done0 && d0cyc < 0) d0cyc = c;
    end
    check("flush_mul done_cycle", dcyc, 46);
    check("flush_mul done_count", dcnt, 1);
    check("flush_mul result", Result, 32'd15);
    check("flush_mul full_done_cycle", d0cyc, 46);
    check("flush_mul full_result", result0, 32'd15);

    // Flush with start in IDLE: op not captured
    @(posedge CLK); #1;
    start = 1'b1; flush = 1'b1; func3 = 3'b000; A = 32'd9; B = 32'd9;
    #1 check("idle_flush stall", stall, 0);
    @(posedge CLK); #1; start = 1'b0; flush = 1'b0;
    #1 check("idle_flush not_captured", stall, 0);
    dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (done || done0) dcnt++;
    end
    check("idle_flush no_done", dcnt, 0);
    check("idle_flush Result", Result, 32'd15);

    // Flush during DONE: pulse still delivered
    @(posedge CLK); #1;
    start = 1'b1; func3 = 3'b100; A = 32'd5; B = 32'd0;              // cycle 0
    @(posedge CLK); #1; start = 1'b0;                                // cycle 1
    @(posedge CLK); #1; flush = 1'b1;                                // cycle 2
    @(negedge CLK);
    check("done_flush done", done, 1);
    check("done_flush Result", Result, 32'hFFFF_FFFF);
    @(posedge CLK); #1; flush = 1'b0;                                // cycle 3
    #1 check("done_flush done_drops", done, 0);
    check("done_flush full_no_done", done0, 0);

    // Reset mid-CALC with start held during reset
    @(posedge CLK); #1;
    start = 1'b1; func3 = 3'b000; A = 32'd7; B = 32'hFFFF_FFFD;      // cycle 0
    @(posedge CLK); #1; start = 1'b0;                                // cycle 1
    repeat (9) @(posedge CLK);
    #1; RST = 1'b1; start = 1'b1; func3 = 3'b000; A = 32'd3; B = 32'd5; // cycle 10
    @(posedge CLK); #1; RST = 1'b0; start = 1'b0;                    // cycle 11
    #1;
    check("rst_mid done", done, 0);
    check("rst_mid Result", Result, 0);
    check("rst_mid stall", stall, 0);
    check("rst_mid full_Result", result0, 0);
    dcnt = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge CLK);
      if (done || done0) dcnt++;
    end
    check("rst_mid no_done", dcnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
